sram_bus_arbiter: RTL
=====================

# sram_bus_arbiter

Shares one SRAM-like memory port between the pipeline's instruction-fetch request and its data-memory request. It sits between the `mips` core (`pcF`/`instrF` and `aluoutM`/`writedataM`/`readdataM`/`selectM`/`memwriteM`/`memreadM`) and the single external memory port. It serialises one transaction at a time, gives data priority over fetch, and produces one pipeline-wide stall until every request presented in the current cycle has completed.

## Interface
Parameters:
- `ADDR_W`, 32, address width on both sides
- `DATA_W`, 32, data width; strobe width is `DATA_W/8`

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `inst_req`  in  1  fetch request; held stable while `stall` is high
- `inst_addr`  in  ADDR_W  fetch address (`pcF`)
- `inst_rdata`  out  DATA_W  registered fetch data (`instrF`)
- `data_req`  in  1  data request (`memreadM | memwriteM`)
- `data_wr`  in  1  1 = store
- `data_wstrb`  in  4  byte enables (`selectM`)
- `data_addr`  in  ADDR_W  data address (`aluoutM`)
- `data_wdata`  in  DATA_W  store data (`writedataM`)
- `data_rdata`  out  DATA_W  registered load data (`readdataM`)
- `flush`  in  1  exception/eret flush; abandons the stage requests
- `stall`  out  1  freezes the whole pipeline
- `mem_req`  out  1  memory request, registered
- `mem_wr`  out  1  registered
- `mem_wstrb`  out  4  registered; 4'hF on reads
- `mem_addr`  out  ADDR_W  registered
- `mem_wdata`  out  DATA_W  registered
- `mem_addr_ok`  in  1  memory accepts the address this cycle
- `mem_data_ok`  in  1  read data / write ack valid this cycle
- `mem_rdata`  in  DATA_W  read data

## Operation
- FSM states: IDLE, D_ADDR, D_WAIT, I_ADDR, I_WAIT.
- IDLE:
  - If a data request is pending (`data_req & ~data_done & ~flush`), latch the `mem_*` fields from the data inputs and go to D_ADDR.
  - Otherwise, if a fetch request is pending (`inst_req & ~inst_done & ~flush`), latch from the fetch inputs (`mem_wr`=0) and go to I_ADDR.
- x_ADDR: `mem_req`=1. When `mem_addr_ok`=1, drop `mem_req` and go to x_WAIT. The request is never withdrawn before `mem_addr_ok`.
- x_WAIT: on `mem_data_ok`:
  - Capture `mem_rdata` into `inst_rdata` (I) or `data_rdata` (D loads only; stores leave it unchanged).
  - Set `inst_done`/`data_done`, unless the transaction was poisoned.
  - Go to IDLE.
- Done flags: `stall` = `(inst_req & ~inst_done) | (data_req & ~data_done)`, combinational. When `stall`=0, both done flags clear at the next edge because the pipeline advances.
- Flush:
  - Clears both done flags.
  - Blocks issue from IDLE in that cycle.
  - An in-flight transaction (x_ADDR/x_WAIT) runs to `mem_data_ok` but is poisoned: its data is discarded and no done flag is set.
  - `stall` is forced to 0 during `flush`.
- Only one memory transaction is outstanding at any time. `mem_data_ok` in IDLE or x_ADDR is ignored.
- Data always wins a simultaneous request, because the data access belongs to the older instruction.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_wr` 0; `mem_wstrb` 0; `mem_addr`, `mem_wdata`, `inst_rdata`, `data_rdata` 0; done flags and poison bit 0.
- Reset mid-transaction abandons it. The memory is reset on the same `rst`.
- Best case, with `mem_addr_ok` and `mem_data_ok` each arriving the first cycle they can:
  - cycle 0: request seen in IDLE
  - cycle 1: `mem_req`=1, address accepted
  - cycle 2: `mem_data_ok` in WAIT
  - cycle 3: done set, `stall`=0, data valid on `*_rdata`
- Both requests together: data is served, then fetch. `stall` drops only after the fetch completes, about 6 cycles.
- `*_rdata` holds its value until the next capture.

## Structure
- A shared package/header `sram_bus_pkg` holds:
  - FSM state encodings
  - `ADDR_W`/`DATA_W` defaults
  - the read strobe constant 4'hF
- No sub-module is needed. The block is a single FSM plus the issue/done/poison registers, about 200 lines.

## Test plan
- **Lone fetch.** `inst_req`=1, `inst_addr`=0xBFC00000, memory returns 0x24080001 with 0-cycle waits.
  - `mem_req` is high exactly 1 cycle.
  - `inst_rdata`=0x24080001 and `stall` falls at cycle 3.
- **Simultaneous requests.**
  - Data store: addr 0x80001000, wdata 0xDEADBEEF, wstrb 4'b0011.
  - Fetch: 0xBFC00004.
  - The store issues first with `mem_wstrb`=0011, then the fetch. `stall` stays high until the fetch `data_ok`.
- **Backpressure.** `mem_addr_ok` is held low for 5 cycles.
  - `mem_req` and all `mem_*` fields stay stable for all 5 cycles.
  - Exactly one transaction is issued.
- **Done-flag hold.** The fetch completes, but the data request's `mem_data_ok` is delayed 4 cycles.
  - The fetch is not re-issued.
  - `inst_rdata` is unchanged until `stall` falls.
- **Flush during D_WAIT.**
  - `stall`=0 in the flush cycle.
  - The late `mem_data_ok` with 0x12345678 does not update `data_rdata` and sets no done flag.
  - The FSM returns to IDLE.
- **Reset mid-transaction.** `rst` asserted in I_WAIT.
  - Next edge: IDLE, `mem_req`=0, `inst_rdata`=0, `stall` reflects only the current requests.

Source files
------------

// File: rtl/sram_bus_pkg.sv
// rtl/sram_bus_pkg.sv - shared types and constants for the SRAM bus arbiter
//
// Purpose: FSM state encoding, default bus widths and the read strobe used by
// the arbiter, its memory-port interface and the bench.
// Ports: none (package).

package sram_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Reads always fetch the whole word.
  localparam logic [3:0] READ_STRB = 4'hF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_ADDR = 3'd1,
    D_WAIT = 3'd2,
    I_ADDR = 3'd3,
    I_WAIT = 3'd4
  } arbState_e;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// rtl/sram_bus_arbiter_if.sv - single external SRAM-like memory port
//
// Purpose: bundles the request/response handshake of the shared memory port.
// Ports (signals):
//   mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata : arbiter -> memory
//   mem_addr_ok, mem_data_ok, mem_rdata             : memory -> arbiter
// Modports: master (arbiter side), slave (memory side).

interface sram_bus_arbiter_if
  import sram_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              mem_req;
  logic              mem_wr;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - shares one memory port between fetch and data
//
// Purpose: serialises instruction-fetch and data-memory requests onto one
// SRAM-like port, one transaction at a time, data before fetch, and holds a
// pipeline-wide stall until every request of the current cycle has completed.
// Ports:
//   clk, rst                                   : clock, sync active-high reset
//   inst_req, inst_addr, inst_rdata            : fetch side
//   data_req, data_wr, data_wstrb, data_addr,
//   data_wdata, data_rdata                     : data side
//   flush                                      : abandons stage requests
//   stall                                      : pipeline freeze
//   mem                                        : external memory port (master)

module sram_bus_arbiter
  import sram_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  input  logic              flush,
  output logic              stall,
  sram_bus_arbiter_if.master mem
);

  arbState_e state, stateNext;

  logic              memReq;
  logic              memWr;
  logic [3:0]        memWstrb;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] instRdata;
  logic [DATA_W-1:0] dataRdata;
  logic              instDone;
  logic              dataDone;
  logic              poison;

  logic issueData;
  logic issueInst;
  logic addrAccept;
  logic txnDone;
  logic txnClean;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext  = state;
    issueData  = 1'b0;
    issueInst  = 1'b0;
    addrAccept = 1'b0;
    txnDone    = 1'b0;
    case (state)
      IDLE: begin
        // Data belongs to the older instruction, so it is served first.
        if (!flush) begin
          if (data_req && !dataDone) begin
            issueData = 1'b1;
            stateNext = D_ADDR;
          end else if (inst_req && !instDone) begin
            issueInst = 1'b1;
            stateNext = I_ADDR;
          end
        end
      end
      D_ADDR: begin
        if (mem.mem_addr_ok) begin
          addrAccept = 1'b1;
          stateNext  = D_WAIT;
        end
      end
      I_ADDR: begin
        if (mem.mem_addr_ok) begin
          addrAccept = 1'b1;
          stateNext  = I_WAIT;
        end
      end
      D_WAIT, I_WAIT: begin
        if (mem.mem_data_ok) begin
          txnDone   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // A completion that coincides with a flush is treated like a poisoned one.
  assign txnClean = txnDone && !poison && !flush;

  assign stall = !flush && ((inst_req && !instDone) || (data_req && !dataDone));

  always_ff @(posedge clk) begin
    if (rst) begin
      memReq    <= 1'b0;
      memWr     <= 1'b0;
      memWstrb  <= 4'h0;
      memAddr   <= '0;
      memWdata  <= '0;
      instRdata <= '0;
      dataRdata <= '0;
      instDone  <= 1'b0;
      dataDone  <= 1'b0;
      poison    <= 1'b0;
    end else begin
      if (issueData) begin
        memReq   <= 1'b1;
        memWr    <= data_wr;
        memWstrb <= data_wr ? data_wstrb : READ_STRB;
        memAddr  <= data_addr;
        memWdata <= data_wdata;
      end else if (issueInst) begin
        memReq   <= 1'b1;
        memWr    <= 1'b0;
        memWstrb <= READ_STRB;
        memAddr  <= inst_addr;
        memWdata <= '0;
      end else if (addrAccept) begin
        memReq <= 1'b0;
      end

      if (txnClean && state == I_WAIT) begin
        instRdata <= mem.mem_rdata;
      end
      if (txnClean && state == D_WAIT && !memWr) begin
        dataRdata <= mem.mem_rdata;
      end

      // Once the pipeline advances (or is flushed) the flags describe a new
      // set of requests and must start clear.
      if (flush || !stall) begin
        instDone <= 1'b0;
        dataDone <= 1'b0;
      end else if (txnClean) begin
        if (state == I_WAIT) begin
          instDone <= 1'b1;
        end else begin
          dataDone <= 1'b1;
        end
      end

      // An in-flight transaction caught by a flush still has to drain on
      // the bus, but its result no longer belongs to anyone.
      if (txnDone) begin
        poison <= 1'b0;
      end else if (flush && state != IDLE) begin
        poison <= 1'b1;
      end
    end
  end

  assign mem.mem_req   = memReq;
  assign mem.mem_wr    = memWr;
  assign mem.mem_wstrb = memWstrb;
  assign mem.mem_addr  = memAddr;
  assign mem.mem_wdata = memWdata;
  assign inst_rdata    = instRdata;
  assign data_rdata    = dataRdata;

endmodule
